count_ctrl: RTL and testbench
=============================

# count_ctrl

Sequencer for the team's small binary counter datapath: accepts a terminal-count configuration through a valid/ready handshake, then starts, pauses, resumes and stops the count on command. It runs either one-shot (stop at terminal and flag done) or auto-reload (wrap to zero and flag each period). It sits between a control master (CPU register block or higher FSM) and the counter, and is the only agent that drives the counter's clear and enable.

## Interface
- WIDTH, 4, counter and terminal-count width (2..16)
- clk  input  1  clock; all state updates on the falling edge, matching the counter datapath
- reset  input  1  asynchronous, active-high
- cfg_valid  input  1  configuration offered this cycle
- cfg_ready  output  1  configuration accepted when cfg_valid & cfg_ready
- cfg_term  input  WIDTH  terminal count to latch
- cfg_mode  input  1  0 = one-shot, 1 = auto-reload
- start  input  1  level-sampled command: begin or resume counting
- stop  input  1  level-sampled command: pause, or abort when already paused
- q  output  WIDTH  current count
- busy  output  1  high in RUN or PAUSE
- done  output  1  one-cycle pulse, one-shot terminal reached
- wrap  output  1  one-cycle pulse, auto-reload terminal reached
- state  output  2  FSM state code, for debug and status readback

## Operation
- States: IDLE=0, RUN=1, PAUSE=2, DONE=3.
- Reset values: state IDLE, q 0, busy 0, done 0, wrap 0, cfg_ready 1. Latched term is all ones; latched mode is one-shot.
- cfg_ready = 1 in IDLE and DONE, 0 in RUN and PAUSE. A handshake latches cfg_term and cfg_mode. cfg_valid is ignored while cfg_ready is 0 and is not queued.
- IDLE or DONE, start=1, stop=0: q←0, go to RUN. If a config handshake occurs in the same cycle, the new term and mode apply to this run.
- RUN, stop=1: go to PAUSE; q holds.
- RUN, q==term, one-shot: go to DONE; q holds term; done=1.
- RUN, q==term, auto-reload: q←0; wrap=1; stay in RUN.
- RUN, otherwise: q←q+1 (mod 2^WIDTH).
- PAUSE, stop=1: abort; q←0, go to IDLE.
- PAUSE, start=1, stop=0: resume RUN from the held q.
- DONE: q holds term until the next start.
- Simultaneous start and stop: stop wins in every state.
- In RUN, stop takes priority over terminal detection.
- term=0:
  - One-shot: DONE on the first RUN edge.
  - Auto-reload: wrap every cycle with q fixed at 0.
- Reset asserted mid-run: all outputs return to reset values immediately (asynchronous). The latched term and mode also revert to their reset values.

## Timing
- Edge numbering: edge 0 is the falling edge at which start is sampled.
- One-shot, term=3, start at edge 0:
  - q = 0, 1, 2, 3 after edges 0..3.
  - Edge 4 detects the terminal: state DONE, done=1 for the cycle after edge 4, cleared at edge 5.
- Run length: term+1 cycles in RUN per one-shot or per reload period.
- Auto-reload, term=3: q sequence 0,1,2,3,0,1,...; wrap is high for one cycle after edges 4, 8, 12, ...
- busy tracks state with zero additional latency, decoded from registered state.
- cfg_ready is decoded from registered state, with no combinational path from cfg_valid.
- Pause and resume add no extra cycles: counting continues from the held value on the first RUN edge.

## Structure
- Package count_ctrl_pkg:
  - state enum (IDLE/RUN/PAUSE/DONE) and its 2-bit encoding
  - mode constants MODE_ONESHOT=0, MODE_RELOAD=1
- Sub-module count_core: WIDTH-bit falling-edge counter with asynchronous reset, synchronous clear and enable. It drives q; count_ctrl produces its clear and enable from the FSM.
- Terminal compare (q==term) lives in count_ctrl.

## Test plan
- Reset with start held high: all outputs at reset values. After release, the first edge enters RUN with q=0.
- Config term=3, one-shot, start: q 0→3 over 4 cycles, done one pulse at edge 4, state DONE, q stays 3, cfg_ready=1.
- Config term=2, auto-reload, run 9 cycles: q 0,1,2,0,1,2,0,1,2; wrap pulses after edges 3 and 6; done never asserts.
- Pause and resume, term=5:
  - Stop at q=2: q holds 2 for 3 cycles; cfg_valid offered then is not accepted.
  - Start: q resumes at 3 and reaches done at q=5.
  - Stop in PAUSE: q=0, IDLE.
- Simultaneous start and stop in IDLE: no transition. In RUN with q==term: PAUSE, no done.
- Edge cases:
  - term=0 auto-reload: wrap high continuously, q stays 0.
  - Asynchronous reset pulse between clock edges mid-run: q, busy and state clear immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/count_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : count_ctrl_pkg
// Description : Shared state encoding and mode constants for the count
//               sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
package count_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_PAUSE = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  localparam logic MODE_ONESHOT = 1'b0;
  localparam logic MODE_RELOAD  = 1'b1;

endpackage
`default_nettype wire

// File: rtl/count_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module      : count_ctrl_if
// Description : Control/status bundle between a control master and the
//               count sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
interface count_ctrl_if #(
  parameter int WIDTH = 4
);
  logic             cfg_valid;
  logic             cfg_ready;
  logic [WIDTH-1:0] cfg_term;
  logic             cfg_mode;
  logic             start;
  logic             stop;
  logic [WIDTH-1:0] q;
  logic             busy;
  logic             done;
  logic             wrap;
  logic [1:0]       state;

  modport master (
    output cfg_valid, cfg_term, cfg_mode, start, stop,
    input  cfg_ready, q, busy, done, wrap, state
  );

  modport slave (
    input  cfg_valid, cfg_term, cfg_mode, start, stop,
    output cfg_ready, q, busy, done, wrap, state
  );
endinterface
`default_nettype wire

// File: rtl/count_core.sv
`default_nettype none
// ============================================================================
// Module      : count_core
// Description : WIDTH-bit falling-edge counter with synchronous clear and
//               enable; clear has priority.
// Revision    : 1.0 - initial release
// ============================================================================
module count_core #(
  parameter int WIDTH = 4
) (
  input  wire logic             clk,
  input  wire logic             reset,
  input  wire logic             clear_i,
  input  wire logic             en_i,
  output logic      [WIDTH-1:0] q_o
);

  logic [WIDTH-1:0] r_count_q;

  always_ff @(negedge clk or posedge reset) begin
    if (reset) begin
      r_count_q <= '0;
    end else if (clear_i) begin
      r_count_q <= '0;
    end else if (en_i) begin
      r_count_q <= r_count_q + WIDTH'(1);
    end
  end

  assign q_o = r_count_q;

endmodule
`default_nettype wire

// File: rtl/count_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : count_ctrl
// Description : Start/pause/stop sequencer for count_core with one-shot and
//               auto-reload terminal handling and a config handshake.
// Revision    : 1.0 - initial release
// ============================================================================
module count_ctrl
  import count_ctrl_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input wire logic   clk,
  input wire logic   reset,
  count_ctrl_if.slave bus
);

  state_t           state_q, state_d;
  logic [WIDTH-1:0] term_q;
  logic             mode_q;
  logic             done_q, done_d;
  logic             wrap_q, wrap_d;

  logic [WIDTH-1:0] w_q;
  logic             w_clear;
  logic             w_en;
  logic             w_busy;
  logic             w_ready;
  logic             w_cfg_fire;
  logic             w_at_term;
  logic             w_go;

  assign w_cfg_fire = bus.cfg_valid & w_ready;
  assign w_at_term  = (w_q == term_q);
  assign w_go       = bus.start & ~bus.stop;

  // State, pulse flags and latched configuration share one register process
  always_ff @(negedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      term_q  <= '1;
      mode_q  <= MODE_ONESHOT;
      done_q  <= 1'b0;
      wrap_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      done_q  <= done_d;
      wrap_q  <= wrap_d;
      if (w_cfg_fire) begin
        term_q <= bus.cfg_term;
        mode_q <= bus.cfg_mode;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (w_go) state_d = ST_RUN;
      end
      ST_RUN: begin
        if (bus.stop)                                state_d = ST_PAUSE;
        else if (w_at_term && mode_q == MODE_ONESHOT) state_d = ST_DONE;
      end
      ST_PAUSE: begin
        if (bus.stop)       state_d = ST_IDLE;
        else if (bus.start) state_d = ST_RUN;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Stop outranks terminal detection, so RUN only counts/wraps when stop is low
  always_comb begin
    w_clear = 1'b0;
    w_en    = 1'b0;
    done_d  = 1'b0;
    wrap_d  = 1'b0;
    w_busy  = 1'b0;
    w_ready = 1'b0;
    case (state_q)
      ST_IDLE, ST_DONE: begin
        w_ready = 1'b1;
        w_clear = w_go;
      end
      ST_RUN: begin
        w_busy = 1'b1;
        if (!bus.stop) begin
          if (w_at_term) begin
            if (mode_q == MODE_ONESHOT) begin
              done_d = 1'b1;
            end else begin
              wrap_d  = 1'b1;
              w_clear = 1'b1;
            end
          end else begin
            w_en = 1'b1;
          end
        end
      end
      ST_PAUSE: begin
        w_busy  = 1'b1;
        w_clear = bus.stop;
      end
      default: ;
    endcase
  end

  count_core #(.WIDTH(WIDTH)) u_core (
    .clk     (clk),
    .reset   (reset),
    .clear_i (w_clear),
    .en_i    (w_en),
    .q_o     (w_q)
  );

  assign bus.q         = w_q;
  assign bus.busy      = w_busy;
  assign bus.cfg_ready = w_ready;
  assign bus.done      = done_q;
  assign bus.wrap      = wrap_q;
  assign bus.state     = state_q;

endmodule
`default_nettype wire

// File: tb/tb_count_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_count_ctrl
// Description : Directed vector bench for count_ctrl (WIDTH=4).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_count_ctrl;

  localparam int W = 4;
  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_RUN   = 2'd1;
  localparam logic [1:0] S_PAUSE = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  typedef struct {
    logic         cv;
    logic [W-1:0] ct;
    logic         cm;
    logic         st;
    logic         sp;
    logic [W-1:0] q;
    logic [1:0]   s;
    logic         d;
    logic         w;
  } vec_t;

  logic clk;
  logic reset;
  int   passed;
  int   total;
  vec_t vecs[$];

  count_ctrl_if #(.WIDTH(W)) bus ();

  count_ctrl #(.WIDTH(W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  // Inputs are driven at the rising edge; the DUT samples on the falling edge
  task automatic step();
    @(negedge clk);
    @(posedge clk);
  endtask

  task automatic drive(input logic cv, input logic [W-1:0] ct, input logic cm,
                       input logic st, input logic sp);
    bus.cfg_valid = cv;
    bus.cfg_term  = ct;
    bus.cfg_mode  = cm;
    bus.start     = st;
    bus.stop      = sp;
  endtask

  task automatic check_all(input string tag, input logic [W-1:0] q, input logic [1:0] s,
                           input logic d, input logic w);
    chk({tag, " q"},     32'(bus.q),         32'(q));
    chk({tag, " state"}, 32'(bus.state),     32'(s));
    chk({tag, " busy"},  32'(bus.busy),      32'(s == S_RUN || s == S_PAUSE));
    chk({tag, " done"},  32'(bus.done),      32'(d));
    chk({tag, " wrap"},  32'(bus.wrap),      32'(w));
    chk({tag, " ready"}, 32'(bus.cfg_ready), 32'(s == S_IDLE || s == S_DONE));
  endtask

  task automatic add(input logic cv, input logic [W-1:0] ct, input logic cm,
                     input logic st, input logic sp, input logic [W-1:0] q,
                     input logic [1:0] s, input logic d, input logic w);
    vec_t v;
    v.cv = cv; v.ct = ct; v.cm = cm; v.st = st; v.sp = sp;
    v.q = q; v.s = s; v.d = d; v.w = w;
    vecs.push_back(v);
  endtask

  initial begin
    passed = 0;
    total  = 0;
    reset  = 1'b1;
    drive(1'b0, '0, 1'b0, 1'b1, 1'b0);

    // cv ct cm st sp | q state done wrap
    // default config (term 15, one-shot): start, pause, abort
    add(0, 0, 0, 1, 0,  0, S_RUN,   0, 0);
    add(0, 0, 0, 1, 0,  1, S_RUN,   0, 0);
    add(0, 0, 0, 0, 1,  1, S_PAUSE, 0, 0);
    add(0, 0, 0, 0, 1,  0, S_IDLE,  0, 0);
    // term 3 one-shot, config and start together
    add(1, 3, 0, 1, 0,  0, S_RUN,   0, 0);
    add(0, 0, 0, 0, 0,  1, S_RUN,   0, 0);
    add(0, 0, 0, 0, 0,  2, S_RUN,   0, 0);
    add(0, 0, 0, 0, 0,  3, S_RUN,   0, 0);
    add(0, 0, 0, 0, 0,  3, S_DONE,  1, 0);
    add(0, 0, 0, 0, 0,  3, S_DONE,  0, 0);
    // term 2 auto-reload for 9 cycles, then pause and abort
    add(1, 2, 1, 1, 0,  0, S_RUN,   0, 0);
    add(0, 0, 0, 0, 0,  1, S_RUN,   0, 0);
    add(0, 0, 0, 0, 0,  2, S_RUN,   0, 0);
    add(0, 0, 0, 0, 0,  0, S_RUN,   0, 1);
    add(0, 0, 0, 0, 0,  1, S_RUN,   0, 0);
    add(0, 0, 0, 0, 0,  2, S_RUN,   0, 0);
    add(0, 0, 0, 0, 0,  0, S_RUN,   0, 1);
    add(0, 0, 0, 0, 0,  1, S_RUN,   0, 0);
    add(0, 0, 0, 0, 0,  2, S_RUN,   0, 0);
    add(0, 0, 0, 0, 1,  2, S_PAUSE, 0, 0);
    add(0, 0, 0, 0, 1,  0, S_IDLE,  0, 0);
    // term 5 one-shot with pause at 2; config offered while paused is dropped
    add(1, 5, 0, 1, 0,  0, S_RUN,   0, 0);
    add(0, 0, 0, 0, 0,  1, S_RUN,   0, 0);
    add(0, 0, 0, 0, 0,  2, S_RUN,   0, 0);
    add(0, 0, 0, 0, 1,  2, S_PAUSE, 0, 0);
    add(1, 1, 1, 0, 0,  2, S_PAUSE, 0, 0);
    add(0, 0, 0, 0, 0,  2, S_PAUSE, 0, 0);
    add(0, 0, 0, 1, 0,  2, S_RUN,   0, 0);
    add(0, 0, 0, 0, 0,  3, S_RUN,   0, 0);
    add(0, 0, 0, 0, 0,  4, S_RUN,   0, 0);
    add(0, 0, 0, 0, 0,  5, S_RUN,   0, 0);
    add(0, 0, 0, 0, 0,  5, S_DONE,  1, 0);
    add(0, 0, 0, 0, 0,  5, S_DONE,  0, 0);
    // start+stop: no move in DONE or IDLE; in RUN at terminal it pauses
    add(0, 0, 0, 1, 1,  5, S_DONE,  0, 0);
    add(0, 0, 0, 1, 0,  0, S_RUN,   0, 0);
    add(0, 0, 0, 0, 1,  0, S_PAUSE, 0, 0);
    add(0, 0, 0, 0, 1,  0, S_IDLE,  0, 0);
    add(0, 0, 0, 1, 1,  0, S_IDLE,  0, 0);
    add(0, 0, 0, 1, 0,  0, S_RUN,   0, 0);
    add(0, 0, 0, 0, 0,  1, S_RUN,   0, 0);
    add(0, 0, 0, 0, 0,  2, S_RUN,   0, 0);
    add(0, 0, 0, 0, 0,  3, S_RUN,   0, 0);
    add(0, 0, 0, 0, 0,  4, S_RUN,   0, 0);
    add(0, 0, 0, 0, 0,  5, S_RUN,   0, 0);
    add(0, 0, 0, 1, 1,  5, S_PAUSE, 0, 0);
    add(0, 0, 0, 1, 0,  5, S_RUN,   0, 0);
    add(0, 0, 0, 0, 0,  5, S_DONE,  1, 0);
    // term 0 auto-reload: continuous wrap at q=0
    add(1, 0, 1, 1, 0,  0, S_RUN,   0, 0);
    add(0, 0, 0, 0, 0,  0, S_RUN,   0, 1);
    add(0, 0, 0, 0, 0,  0, S_RUN,   0, 1);
    add(0, 0, 0, 0, 0,  0, S_RUN,   0, 1);
    add(0, 0, 0, 0, 1,  0, S_PAUSE, 0, 0);
    add(0, 0, 0, 0, 1,  0, S_IDLE,  0, 0);
    // term 0 one-shot: DONE on the first RUN edge
    add(1, 0, 0, 1, 0,  0, S_RUN,   0, 0);
    add(0, 0, 0, 0, 0,  0, S_DONE,  1, 0);

    // Reset held with start high
    step();
    step();
    check_all("reset", 0, S_IDLE, 0, 0);
    reset = 1'b0;

    for (int i = 0; i < vecs.size(); i++) begin
      drive(vecs[i].cv, vecs[i].ct, vecs[i].cm, vecs[i].st, vecs[i].sp);
      step();
      check_all($sformatf("vec%0d", i), vecs[i].q, vecs[i].s, vecs[i].d, vecs[i].w);
    end

    // Asynchronous reset mid-run, between falling edges
    drive(1'b1, 4'd7, 1'b1, 1'b1, 1'b0);
    step();
    drive(1'b0, '0, 1'b0, 1'b0, 1'b0);
    step();
    step();
    step();
    chk("pre-reset q", 32'(bus.q), 32'd3);
    #2 reset = 1'b1;
    #1;
    chk("async q",     32'(bus.q),         32'd0);
    chk("async state", 32'(bus.state),     32'(S_IDLE));
    chk("async busy",  32'(bus.busy),      32'd0);
    chk("async ready", 32'(bus.cfg_ready), 32'd1);
    @(negedge clk);
    @(posedge clk);
    reset = 1'b0;

    // Latched config must be back to term=15, one-shot
    drive(1'b0, '0, 1'b0, 1'b1, 1'b0);
    step();
    drive(1'b0, '0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 15; i++) step();
    check_all("post-reset run", 15, S_RUN, 0, 0);
    step();
    check_all("post-reset done", 15, S_DONE, 1, 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
`default_nettype wire
